weight_stream_ram: RTL and testbench

WEIGHT_STREAM_RAM -- requirements
Module: weight_stream_ram

---
 rtl/weight_stream_ram.sv | 162 ++++++++++++++++
 tb/tb_weight_stream_ram.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_ram.sv
// Row-wide weight store: rows are loaded while idle, then streamed out as a
// contiguous (wrapping) run with ready/valid backpressure. Optional WSR_PARITY_EN adds per-row even parity.
module weight_stream_ram #(
    parameter  int NROW     = 256,
    parameter  int NCOL     = 256,
    parameter  int BITWIDTH = 18,
    localparam int ROW_W    = BITWIDTH * NROW,
    localparam int AW       = $clog2(NCOL),
    localparam int CW       = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [CW-1:0]    count,
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] out_data,
    output logic             out_last
`ifdef WSR_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    // state | meaning
    // IDLE  | accepting row writes, waiting for start
    // RUN   | issuing reads and streaming rows
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef WSR_PARITY_EN
    localparam int MW = ROW_W + 1;
`else
    localparam int MW = ROW_W;
`endif

    state_t          state_q, state_d;
    logic [MW-1:0]   mem [NCOL];
    logic [MW-1:0]   wr_word;
    logic            wr_fire;
    logic [AW-1:0]   rd_addr;
    logic [CW-1:0]   remaining;
    logic            issue, pop, load_out;
    logic [1:0]      occ, occ_after;
    logic            p1_v, p1_last, skid_v, skid_last, out_v;
    logic [MW-1:0]   p1_q, skid_q, out_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        wr_ready = 1'b0;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                wr_ready = !start;
                if (start) state_d = (count == '0) ? DONE : RUN;
            end
            RUN:  if (pop && out_last) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WSR_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif
    assign wr_fire = wr_valid && wr_ready;

    // Credit check: out register + skid give two slots; a read is issued only
    // if the row it returns is guaranteed a slot.
    assign pop       = out_v && out_ready;
    assign load_out  = !out_v || out_ready;
    assign occ       = 2'(out_v) + 2'(skid_v) + 2'(p1_v);
    assign occ_after = occ - 2'(pop);
    assign issue     = (state_q == RUN) && (remaining != '0) && (occ_after < 2'd2);

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_addr] <= wr_word;
        if (issue)   p1_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr   <= '0;
            remaining <= '0;
            p1_v      <= 1'b0;
            p1_last   <= 1'b0;
            skid_v    <= 1'b0;
            skid_last <= 1'b0;
            skid_q    <= '0;
            out_v     <= 1'b0;
            out_last  <= 1'b0;
            out_q     <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                rd_addr   <= base_addr;
                remaining <= count;
            end else if (issue) begin
                rd_addr   <= rd_addr + AW'(1);
                remaining <= remaining - CW'(1);
            end
            p1_v    <= issue;
            p1_last <= issue && (remaining == CW'(1));

            if (load_out) begin
                if (skid_v) begin
                    out_v     <= 1'b1;
                    out_q     <= skid_q;
                    out_last  <= skid_last;
                    skid_v    <= p1_v;
                    skid_q    <= p1_q;
                    skid_last <= p1_last;
                end else if (p1_v) begin
                    out_v    <= 1'b1;
                    out_q    <= p1_q;
                    out_last <= p1_last;
                end else begin
                    out_v    <= 1'b0;
                    out_last <= 1'b0;
                end
            end else if (p1_v) begin
                skid_v    <= 1'b1;
                skid_q    <= p1_q;
                skid_last <= p1_last;
            end
        end
    end

    assign out_valid = out_v;
    assign out_data  = out_q[ROW_W-1:0];

`ifdef WSR_PARITY_EN
    logic par_bad, par_sticky;
    assign par_bad = out_v && ((^out_q[ROW_W-1:0]) != out_q[ROW_W]);

    always_ff @(posedge clk) begin
        if (reset)        par_sticky <= 1'b0;
        else if (par_bad) par_sticky <= 1'b1;
    end

    assign parity_err = par_sticky || par_bad;
`endif

endmodule

// File: tb/tb_weight_stream_ram.sv
// Scoreboard bench for weight_stream_ram (NROW=4, NCOL=8, BITWIDTH=8).
module tb_weight_stream_ram;
    localparam int NC = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic [2:0]  base_addr;
    logic [3:0]  count;
    logic        busy, done, out_valid, out_ready, out_last;
    logic [31:0] out_data;
`ifdef WSR_PARITY_EN
    logic        parity_err;
`endif

    weight_stream_ram #(.NROW(4), .NCOL(8), .BITWIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef WSR_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];
    logic [31:0] model [NC];

    int first_v, last_acc_cyc, done_cyc, n_acc, n_done, n_valid;
    logic        prev_stall;
    logic [31:0] held_data;
    logic        held_last;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops, hold-stability during stalls, done timing
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, held_data);
                chk("stall_last", 32'(out_last), 32'(held_last));
            end
            if (out_valid) begin
                n_valid++;
                if (first_v < 0) first_v = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", out_data, 32'hxxxxxxxx);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("row_data", out_data, e[31:0]);
                    chk("row_last", 32'(out_last), 32'(e[32]));
                end
                n_acc++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    task automatic clear_stats();
        first_v = -1; n_acc = 0; n_done = 0; n_valid = 0;
        last_acc_cyc = 0; done_cyc = 0;
    endtask

    task automatic stream(input int b, input int c, input bit bp, input bit bw);
        int sc;
        for (int i = 0; i < c; i++) begin
            int a;
            a = (b + i) % NC;
            exp_q.push_back({(i == c - 1) ? 1'b1 : 1'b0, model[a]});
        end
        clear_stats();
        base_addr = 3'(b);
        count     = 4'(c);
        start     = 1'b1;
        out_ready = 1'b1;
        if (bw) begin
            wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 32'hDEADBEEF;
            #1;
            chk("wr_ready_start_prio", 32'(wr_ready), 32'd0);
        end
        tick();
        sc = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        if (bw) chk("wr_ready_busy", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 80 && n_done == 0; i++) begin
            out_ready = bp ? ((i % 3) != 0) : 1'b1;
            tick();
        end
        wr_valid  = 1'b0;
        out_ready = 1'b1;
        chk("done_count", 32'(n_done), 32'd1);
        chk("rows_accepted", 32'(n_acc), 32'(c));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (c == 0) begin
            chk("cnt0_no_valid", 32'(n_valid), 32'd0);
            chk("cnt0_done_lat", 32'(done_cyc - sc), 32'd0);
        end else begin
            chk("done_after_last", 32'(done_cyc - last_acc_cyc), 32'd1);
            if (!bp) begin
                chk("first_latency", 32'(first_v - sc), 32'd2);
                chk("consecutive", 32'(last_acc_cyc - first_v), 32'(c - 1));
            end
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        prev_stall = 1'b0;
        clear_stats();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_wr_ready_init", 32'(wr_ready), 32'd1);

        for (int a = 0; a < NC; a++) begin
            model[a] = 32'(a) * 32'h01010101;
            wr_valid = 1'b1; wr_addr = 3'(a); wr_data = model[a];
            #1;
            chk("wr_ready_idle", 32'(wr_ready), 32'd1);
            tick();
        end
        wr_valid = 1'b0;

        stream(0, 8, 1'b0, 1'b0);   // full load-and-stream
        stream(6, 4, 1'b0, 1'b0);   // wrap 6,7,0,1
        stream(1, 5, 1'b1, 1'b0);   // backpressure
        stream(0, 0, 1'b0, 1'b0);   // count=0
        stream(0, 3, 1'b0, 1'b1);   // writes attempted while busy
        stream(7, 8, 1'b0, 1'b0);   // readback everything, row 2 untouched

        // Mid-stream reset after 2 of 6 rows
        for (int i = 0; i < 6; i++) exp_q.push_back({(i == 5) ? 1'b1 : 1'b0, model[i]});
        clear_stats();
        base_addr = 3'd0; count = 4'd6; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && n_acc < 2; i++) tick();
        chk("abort_two_rows", 32'(n_acc), 32'd2);
        reset = 1'b1; out_ready = 1'b0;
        tick();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wr_ready", 32'(wr_ready), 32'd1);
        reset = 1'b0; out_ready = 1'b1;
        exp_q.delete();
        n_done = 0; n_valid = 0;
        repeat (6) tick();
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_no_rows", 32'(n_valid), 32'd0);
        stream(0, 8, 1'b0, 1'b0);   // contents survive reset

`ifdef WSR_PARITY_EN
        chk("par_clear", 32'(parity_err), 32'd0);
        dut.mem[3][0] = ~dut.mem[3][0];
        model[3][0]   = ~model[3][0];
        stream(0, 8, 1'b0, 1'b0);
        chk("par_set", 32'(parity_err), 32'd1);
        tick();
        chk("par_sticky", 32'(parity_err), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
